// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch constants, next-PC source codes and
// fetch-sequencer FSM state encodings.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_4FFF;

  // Instruction memory word-address width (8 KiB of 32-bit words).
  localparam int IM_AW = 11;

  // Next-PC source selected by the D stage.
  typedef enum logic [2:0] {
    PC_SRC_SEQ = 3'd0,
    PC_SRC_BR1 = 3'd1,
    PC_SRC_BR2 = 3'd2,
    PC_SRC_BR3 = 3'd3,
    PC_SRC_EPC = 3'd4
  } pc_src_e;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_range_chk.sv
// Combinational address range / alignment checker with word-address
// derivation. Defaults cover the instruction memory; the load/store unit
// can instantiate it with its own window.
module fetch_range_chk
  import cpu_defs::*;
#(
  parameter logic [31:0] LO_ADDR = IM_LO,
  parameter logic [31:0] HI_ADDR = IM_HI
) (
  input  logic [31:0]      addr_i,
  output logic [IM_AW-1:0] word_addr_o,
  output logic             error_o
);

  // Word address relative to the window base, plus the legality flag.
  // LO_ADDR is word aligned, so subtracting only the word-index bits gives
  // the same result as slicing the full 32-bit difference.
  always_comb begin
    word_addr_o = addr_i[IM_AW+1:2] - LO_ADDR[IM_AW+1:2];
    error_o     = (addr_i < LO_ADDR) || (addr_i > HI_ADDR) ||
                  (addr_i[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: fetch PC register, prioritised next-PC selection,
// IF/ID flush, delay-slot tag and fetch-range error.
module fetch_sequencer
  import cpu_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             int_req,
  input  logic [2:0]       pc_src_d,
  input  logic [31:0]      pc_branch1_d,
  input  logic [31:0]      pc_branch2_d,
  input  logic [31:0]      pc_branch3_d,
  input  logic [31:0]      epc,
  input  logic             branch_d,
  output logic [31:0]      pc_f,
  output logic [31:0]      pc_plus4_f,
  output logic [IM_AW-1:0] im_addr,
  output logic             flush_d,
  output logic             at_delay_slot_f,
  output logic             error_f,
  output logic [1:0]       state_o
);

  logic [31:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;
  logic         flush_c;
  logic         range_err;

  fetch_range_chk u_range_chk (
    .addr_i      (pc_q),
    .word_addr_o (im_addr),
    .error_o     (range_err)
  );

  assign pc_plus4_f = pc_q + 32'd4;  // wraps modulo 2^32 by width

  // Next-PC, next-state and flush selection in fixed priority order.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pc_d    = pc_q;
    state_d = state_q;
    flush_c = 1'b0;
    if (int_req) begin
      pc_d    = EXC_PC;
      state_d = ST_REDIR;
      flush_c = 1'b1;
    end else if (state_q == ST_FAULT) begin
      // Parked until an interrupt or reset; keep bubbling IF/ID.
      flush_c = 1'b1;
    end else if (stall_f) begin
      // Hold PC and state; IF/ID keeps its contents.
    end else if (range_err) begin
      // Illegal fetch: park here instead of running off into garbage.
      state_d = ST_FAULT;
      flush_c = 1'b1;
    end else if (state_q == ST_REDIR) begin
      // D holds a bubble, so its pc_src_d is meaningless.
      pc_d    = pc_plus4_f;
      state_d = ST_RUN;
    end else begin
      case (pc_src_d)
        PC_SRC_EPC: begin
          // eret has no delay slot: squash the instruction behind it.
          pc_d    = epc;
          state_d = ST_REDIR;
          flush_c = 1'b1;
        end
        PC_SRC_BR1: pc_d = pc_branch1_d;
        PC_SRC_BR2: pc_d = pc_branch2_d;
        PC_SRC_BR3: pc_d = pc_branch3_d;
        default:    pc_d = pc_plus4_f;
      endcase
    end
  end

  // PC and FSM state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc_f            = pc_q;
  assign error_f         = range_err;
  assign state_o         = state_q;
  // Reset wins over everything, including a coincident int_req or branch_d.
  assign flush_d         = flush_c & ~reset;
  assign at_delay_slot_f = branch_d & (state_q == ST_RUN) & ~reset;

endmodule
